soc_system_pio_sensor_in: RTL and testbench

Avalon-MM slave input port that gives the HPS a clean, debounced view of up to WIDTH track-sensor lines (lap/lane detectors), the receiving counterpart to the motor-control output PIO. Inputs are synchronized, debounced per bit with a software-programmable threshold, and edge-captured. Captured edges raise a maskable, level-sensitive interrupt. The block sits on the lightweight HPS-to-FPGA bridge next to the other PIO slaves.

---
 rtl/soc_system_pio_sensor_in.sv | 122 ++++++++++++
 tb/tb_soc_system_pio_sensor_in.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/soc_system_pio_sensor_in.sv
// soc_system_pio_sensor_in
//   Avalon-MM input PIO for the track sensors (lap/lane detectors). Each line
//   is brought into clk through a two-flop synchronizer. It is then debounced
//   against a programmable threshold, and its transitions are edge-captured.
//   Captured edges drive a maskable, level-sensitive interrupt.
//
// Ports
//   clk         system clock, rising edge
//   reset       synchronous active-high reset
//   address     register select: 0 DATA, 1 DEBOUNCE, 2 IRQMASK, 3 EDGECAP
//   chipselect  slave select
//   write_n     active-low write strobe, qualified by chipselect
//   writedata   write data
//   readdata    combinational read data, unused bits zero
//   in_port     asynchronous sensor inputs
//   irq         registered interrupt request
module soc_system_pio_sensor_in #(
  parameter int unsigned            WIDTH          = 8,
  parameter int unsigned            CNT_W          = 16,
  parameter logic [CNT_W-1:0]       DEBOUNCE_RESET = 16'd500,
  parameter int unsigned            EDGE_TYPE      = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam bit CAP_RISE = (EDGE_TYPE == 0) || (EDGE_TYPE == 2);
  localparam bit CAP_FALL = (EDGE_TYPE == 1) || (EDGE_TYPE == 2);

  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic [WIDTH-1:0] irqmask_q, irqmask_d;
  logic [CNT_W-1:0] debounce_q, debounce_d;
  logic             irq_q, irq_d;

  logic             wr_en;
  logic [WIDTH-1:0] edge_set;
  logic             unused_wdata;

  assign wr_en        = chipselect && !write_n;
  assign unused_wdata = ^writedata;

  always_comb begin
    sync1_d    = in_port;
    sync2_d    = sync1_q;
    stable_d   = stable_q;
    cnt_d      = cnt_q;
    edge_set   = '0;
    irqmask_d  = irqmask_q;
    debounce_d = debounce_q;

    // The counter clears whenever the line agrees with the stable value, so
    // only an uninterrupted run of DEBOUNCE+1 mismatching cycles commits.
    for (int i = 0; i < WIDTH; i++) begin
      if (sync2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] >= debounce_q) begin
        stable_d[i] = sync2_q[i];
        cnt_d[i]    = '0;
        edge_set[i] = sync2_q[i] ? CAP_RISE : CAP_FALL;
      end else if (cnt_q[i] != {CNT_W{1'b1}}) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end

    if (wr_en && address == 2'd1) debounce_d = writedata[CNT_W-1:0];
    if (wr_en && address == 2'd2) irqmask_d  = writedata[WIDTH-1:0];

    // A new edge is ORed in after the write-1-clear, so it wins a collision.
    edgecap_d = edgecap_q;
    if (wr_en && address == 2'd3) edgecap_d = edgecap_q & ~writedata[WIDTH-1:0];
    edgecap_d = edgecap_d | edge_set;

    irq_d = |(edgecap_q & irqmask_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      stable_q   <= '0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
      edgecap_q  <= '0;
      irqmask_q  <= '0;
      debounce_q <= DEBOUNCE_RESET;
      irq_q      <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      stable_q   <= stable_d;
      cnt_q      <= cnt_d;
      edgecap_q  <= edgecap_d;
      irqmask_q  <= irqmask_d;
      debounce_q <= debounce_d;
      irq_q      <= irq_d;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      2'd0:    readdata[WIDTH-1:0] = stable_q;
      2'd1:    readdata[CNT_W-1:0] = debounce_q;
      2'd2:    readdata[WIDTH-1:0] = irqmask_q;
      default: readdata[WIDTH-1:0] = edgecap_q;
    endcase
  end

  assign irq = irq_q;

endmodule

// File: tb/tb_soc_system_pio_sensor_in.sv
module tb_soc_system_pio_sensor_in;

  logic        clk;
  logic        reset;
  logic [1:0]  address;
  logic        write_n;
  logic [31:0] writedata;
  logic        cs0, cs2;
  logic [7:0]  in0, in2;
  logic [31:0] rd0, rd2;
  logic        irq0, irq2;

  int n_cmp = 0;
  int n_bad = 0;

  soc_system_pio_sensor_in #(.EDGE_TYPE(0)) dut0 (
    .clk(clk), .reset(reset), .address(address), .chipselect(cs0),
    .write_n(write_n), .writedata(writedata), .readdata(rd0),
    .in_port(in0), .irq(irq0)
  );

  soc_system_pio_sensor_in #(.EDGE_TYPE(2)) dut2 (
    .clk(clk), .reset(reset), .address(address), .chipselect(cs2),
    .write_n(write_n), .writedata(writedata), .readdata(rd2),
    .in_port(in2), .irq(irq2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input bit sel, input logic [1:0] a, input logic [31:0] d);
    address   = a;
    writedata = d;
    write_n   = 1'b0;
    if (sel) cs2 = 1'b1;
    else     cs0 = 1'b1;
    tick();
    write_n = 1'b1;
    cs0     = 1'b0;
    cs2     = 1'b0;
  endtask

  task automatic rd(input bit sel, input logic [1:0] a, input logic [31:0] exp, input string tag);
    address = a;
    #1;
    chk(tag, sel ? rd2 : rd0, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; address = 2'd0; write_n = 1'b1; writedata = '0;
    cs0 = 1'b0; cs2 = 1'b0; in0 = '0; in2 = '0;
    tick(2);
    reset = 1'b0;

    // Reset defaults
    rd(0, 2'd0, 32'd0,   "rst_data");
    rd(0, 2'd1, 32'd500, "rst_debounce");
    rd(0, 2'd2, 32'd0,   "rst_mask");
    rd(0, 2'd3, 32'd0,   "rst_edgecap");
    chk("rst_irq", {31'd0, irq0}, 32'd0);

    // Pass-through timing with DEBOUNCE=0
    wr(0, 2'd1, 32'd0);
    wr(0, 2'd2, 32'd1);
    rd(0, 2'd1, 32'd0, "pt_debounce_rb");
    in0 = 8'h01;
    tick(2);
    rd(0, 2'd0, 32'h00, "pt_data_e1");
    tick();
    rd(0, 2'd0, 32'h01, "pt_data_e2");
    rd(0, 2'd3, 32'h01, "pt_edgecap_e2");
    chk("pt_irq_e2", {31'd0, irq0}, 32'd0);
    tick();
    chk("pt_irq_e3", {31'd0, irq0}, 32'd1);

    // Write-1-clear; irq falls one cycle later
    wr(0, 2'd3, 32'h01);
    rd(0, 2'd3, 32'h00, "clr_edgecap");
    chk("clr_irq_k", {31'd0, irq0}, 32'd1);
    tick();
    chk("clr_irq_k1", {31'd0, irq0}, 32'd0);

    // Falling edge ignored for rising-only capture
    in0 = 8'h00;
    tick(3);
    rd(0, 2'd0, 32'h00, "fall_data");
    rd(0, 2'd3, 32'h00, "fall_nocap");

    // Glitch rejection: 4-cycle pulse with DEBOUNCE=4
    wr(0, 2'd1, 32'd4);
    in0 = 8'h08;
    tick(4);
    in0 = 8'h00;
    tick(8);
    rd(0, 2'd0, 32'h00, "glitch_data");
    rd(0, 2'd3, 32'h00, "glitch_edgecap");

    // Held pulse commits at edge 6
    in0 = 8'h08;
    tick(6);
    rd(0, 2'd0, 32'h00, "hold_data_e5");
    tick();
    rd(0, 2'd0, 32'h08, "hold_data_e6");
    rd(0, 2'd3, 32'h08, "hold_edgecap_e6");
    tick();
    chk("hold_irq_masked", {31'd0, irq0}, 32'd0);
    wr(0, 2'd3, 32'h08);

    // Clear/set collision on bit 1
    wr(0, 2'd1, 32'd0);
    wr(0, 2'd2, 32'h02);
    in0 = 8'h0A;
    tick(3);
    rd(0, 2'd3, 32'h02, "col_first_cap");
    tick();
    chk("col_irq_first", {31'd0, irq0}, 32'd1);
    in0 = 8'h08;
    tick(3);
    rd(0, 2'd0, 32'h08, "col_low_data");
    rd(0, 2'd3, 32'h02, "col_low_edgecap");
    in0 = 8'h0A;
    tick(2);
    wr(0, 2'd3, 32'h02);
    rd(0, 2'd3, 32'h02, "col_edgecap_kept");
    chk("col_irq_k", {31'd0, irq0}, 32'd1);
    tick();
    chk("col_irq_k1", {31'd0, irq0}, 32'd1);
    rd(0, 2'd0, 32'h0A, "col_data");

    // Masking
    wr(0, 2'd3, 32'h02);
    wr(0, 2'd2, 32'h00);
    in0 = 8'h8A;
    tick(3);
    rd(0, 2'd3, 32'h80, "mask_edgecap");
    tick();
    chk("mask_irq_off", {31'd0, irq0}, 32'd0);
    wr(0, 2'd2, 32'h80);
    chk("mask_irq_k", {31'd0, irq0}, 32'd0);
    tick();
    chk("mask_irq_k1", {31'd0, irq0}, 32'd1);
    wr(0, 2'd3, 32'h80);
    chk("mask_clr_irq_k", {31'd0, irq0}, 32'd1);
    tick();
    chk("mask_clr_irq_k1", {31'd0, irq0}, 32'd0);
    rd(0, 2'd3, 32'h00, "mask_edgecap_clr");

    // Any-edge instance
    wr(1, 2'd1, 32'd0);
    wr(1, 2'd2, 32'd1);
    in2 = 8'h01;
    tick(3);
    rd(1, 2'd0, 32'h01, "any_rise_data");
    rd(1, 2'd3, 32'h01, "any_rise_cap");
    tick();
    chk("any_irq", {31'd0, irq2}, 32'd1);
    wr(1, 2'd3, 32'h01);
    in2 = 8'h00;
    tick(3);
    rd(1, 2'd0, 32'h00, "any_fall_data");
    rd(1, 2'd3, 32'h01, "any_fall_cap");
    wr(1, 2'd3, 32'h01);
    rd(1, 2'd3, 32'h00, "any_clr");

    // Reset mid-count with DEBOUNCE=100 at count 50
    wr(1, 2'd1, 32'd100);
    in2 = 8'h01;
    tick(52);
    rd(1, 2'd0, 32'h00, "mid_data");
    rd(1, 2'd3, 32'h00, "mid_nocap");
    reset = 1'b1;
    tick(2);
    rd(1, 2'd0, 32'h00,  "rstmid_data");
    rd(1, 2'd3, 32'h00,  "rstmid_edgecap");
    rd(1, 2'd1, 32'd500, "rstmid_debounce");
    reset = 1'b0;

    // Line held high through reset comes back as a rising edge
    wr(1, 2'd1, 32'd3);
    tick(4);
    rd(1, 2'd0, 32'h00, "post_rst_e4");
    tick();
    rd(1, 2'd0, 32'h01, "post_rst_e5");
    rd(1, 2'd3, 32'h01, "post_rst_cap");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
